// File: rtl/sm4_pkg.sv
// Shared constants, types and the S-box for the SM4 key-schedule controller.
package sm4_pkg;

  localparam int ROUNDS = 32;

  localparam logic [31:0] FK0 = 32'hA3B1BAC6;
  localparam logic [31:0] FK1 = 32'h56AA3350;
  localparam logic [31:0] FK2 = 32'h677D9197;
  localparam logic [31:0] FK3 = 32'hB27022DC;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  // Byte substitution through the SM4 S-box.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/sm4_tprime.sv
// Key-path round transform: byte-wise S-box (tau) followed by the linear map L'.
module sm4_tprime
  import sm4_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  logic [31:0] subst;

  // tau on each byte, then L'(B) = B ^ (B<<<13) ^ (B<<<23).
  always_comb begin
    subst = {sbox(din[31:24]), sbox(din[23:16]), sbox(din[15:8]), sbox(din[7:0])};
    dout  = subst ^ {subst[18:0], subst[31:19]} ^ {subst[8:0], subst[31:9]};
  end

endmodule

// File: rtl/sm4_key_sched_ctrl.sv
// SM4 key-expansion controller: accepts a master key, produces one round key
// per cycle using an external registered CK ROM, streams the keys out and
// stores them in a 32-entry round-key file readable in forward or reverse order.
module sm4_key_sched_ctrl
  import sm4_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  output logic         rk_valid,
  output logic [4:0]   rk_idx,
  output logic [31:0]  rk_data,
  output logic         done,
  output logic         busy,
  output logic         keys_ok,
  input  logic [4:0]   rd_idx,
  input  logic         rd_dec,
  output logic [31:0]  rd_data,
  output logic [4:0]   ck_idx,
  input  logic [31:0]  ck_in
);

  localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

  state_t      state;
  state_t      state_next;
  logic [4:0]  cnt;
  logic [31:0] k0;
  logic [31:0] k1;
  logic [31:0] k2;
  logic [31:0] k3;
  logic [31:0] t_word;
  logic [31:0] t_prime;
  logic [31:0] rk_next;
  logic        accept;
  logic [4:0]  rd_addr;
  logic [31:0] key_file [ROUNDS];

  // One round of the schedule: rk_i = K0 ^ L'(tau(K1 ^ K2 ^ K3 ^ CK_i)).
  assign t_word  = k1 ^ k2 ^ k3 ^ ck_in;
  assign rk_next = k0 ^ t_prime;
  assign accept  = key_valid && key_ready;
  assign rd_addr = rd_dec ? (LAST_ROUND - rd_idx) : rd_idx;

  sm4_tprime u_tprime (
    .din  (t_word),
    .dout (t_prime)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: start on an accepted key, stop after the last round.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (key_valid) state_next = RUN;
      RUN:     if (cnt == LAST_ROUND) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore outputs: ready while idle, CK ROM address runs one round ahead.
  always_comb begin
    key_ready = (state == IDLE);
    ck_idx    = (state == RUN) ? 5'(cnt + 5'd1) : 5'd0;
  end

  // Key registers, round counter and the round-key stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= 5'd0;
      k0       <= 32'd0;
      k1       <= 32'd0;
      k2       <= 32'd0;
      k3       <= 32'd0;
      rk_valid <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      keys_ok  <= 1'b0;
      rk_idx   <= 5'd0;
      rk_data  <= 32'd0;
    end else begin
      rk_valid <= 1'b0;
      done     <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          k0      <= key_in[127:96] ^ FK0;
          k1      <= key_in[95:64]  ^ FK1;
          k2      <= key_in[63:32]  ^ FK2;
          k3      <= key_in[31:0]   ^ FK3;
          cnt     <= 5'd0;
          keys_ok <= 1'b0;
          busy    <= 1'b1;
        end
      end else begin
        k0       <= k1;
        k1       <= k2;
        k2       <= k3;
        k3       <= rk_next;
        rk_data  <= rk_next;
        rk_idx   <= cnt;
        rk_valid <= 1'b1;
        cnt      <= 5'(cnt + 5'd1);
        if (cnt == LAST_ROUND) begin
          busy    <= 1'b0;
          done    <= 1'b1;
          keys_ok <= 1'b1;
        end
      end
    end
  end

  // Round-key file write; contents survive reset and are qualified by keys_ok.
  always_ff @(posedge clk) begin
    if (state == RUN) key_file[cnt] <= rk_next;
  end

  // Registered read port, forward or reverse order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= 32'd0;
    else        rd_data <= key_file[rd_addr];
  end

endmodule

// File: tb/tb_sm4_key_sched_ctrl.sv
// Directed self-checking bench for sm4_key_sched_ctrl with an independent
// reference key schedule and a registered CK ROM model.
module tb_sm4_key_sched_ctrl;

  logic         clk;
  logic         rst_n;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_in;
  logic         rk_valid;
  logic [4:0]   rk_idx;
  logic [31:0]  rk_data;
  logic         done;
  logic         busy;
  logic         keys_ok;
  logic [4:0]   rd_idx;
  logic         rd_dec;
  logic [31:0]  rd_data;
  logic [4:0]   ck_idx;
  logic [31:0]  ck_in;

  int checks;
  int failures;

  logic [31:0] exp_rk [32];
  logic [31:0] got_rk [32];

  localparam logic [127:0] KEY_A = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] KEY_B = 128'h00112233445566778899AABBCCDDEEFF;

  logic [2047:0] sbox_bits = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  sm4_key_sched_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_in    (key_in),
    .rk_valid  (rk_valid),
    .rk_idx    (rk_idx),
    .rk_data   (rk_data),
    .done      (done),
    .busy      (busy),
    .keys_ok   (keys_ok),
    .rd_idx    (rd_idx),
    .rd_dec    (rd_dec),
    .rd_data   (rd_data),
    .ck_idx    (ck_idx),
    .ck_in     (ck_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CK_i byte j = (4i+j)*7 mod 256, most significant byte first.
  function automatic logic [31:0] ck_word(input int i);
    logic [31:0] w;
    for (int j = 0; j < 4; j++) w[31 - 8*j -: 8] = 8'(((4*i + j) * 7) % 256);
    return w;
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] x);
    return sbox_bits[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // Registered CK ROM: one-cycle latency from ck_idx to ck_in.
  always @(posedge clk) ck_in <= ck_word(int'(ck_idx));

  // Reference key expansion written from the algorithm definition.
  task automatic build_ref(input logic [127:0] mk);
    logic [31:0] k [4];
    logic [31:0] tw;
    logic [31:0] bw;
    logic [31:0] rk;
    k[0] = mk[127:96] ^ 32'hA3B1BAC6;
    k[1] = mk[95:64]  ^ 32'h56AA3350;
    k[2] = mk[63:32]  ^ 32'h677D9197;
    k[3] = mk[31:0]   ^ 32'hB27022DC;
    for (int i = 0; i < 32; i++) begin
      tw = k[1] ^ k[2] ^ k[3] ^ ck_word(i);
      bw = {sb(tw[31:24]), sb(tw[23:16]), sb(tw[15:8]), sb(tw[7:0])};
      rk = k[0] ^ bw ^ rotl(bw, 13) ^ rotl(bw, 23);
      exp_rk[i] = rk;
      k[0] = k[1];
      k[1] = k[2];
      k[2] = k[3];
      k[3] = rk;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers mk in the current (idle) cycle and checks cycles 1..33 after the
  // accept. With hold_next the next key is held valid during the run, and the
  // task returns in cycle 33 where that key is being accepted.
  task automatic applyStimulus(input logic [127:0] mk, input logic hold_next, input logic [127:0] next_mk);
    build_ref(mk);
    key_valid = 1'b1;
    key_in    = mk;
    checkOutput("accept_ready", 32'(key_ready), 32'd1);
    step();
    if (hold_next) key_in = next_mk;
    else           key_valid = 1'b0;
    for (int cyc = 1; cyc <= 33; cyc++) begin
      checkOutput($sformatf("key_ready c%0d", cyc), 32'(key_ready), 32'(cyc == 33));
      checkOutput($sformatf("busy c%0d", cyc), 32'(busy), 32'(cyc <= 32));
      checkOutput($sformatf("ck_idx c%0d", cyc), 32'(ck_idx), (cyc <= 32) ? 32'(cyc % 32) : 32'd0);
      checkOutput($sformatf("rk_valid c%0d", cyc), 32'(rk_valid), 32'(cyc >= 2));
      checkOutput($sformatf("done c%0d", cyc), 32'(done), 32'(cyc == 33));
      checkOutput($sformatf("keys_ok c%0d", cyc), 32'(keys_ok), 32'(cyc == 33));
      if (cyc >= 2) begin
        got_rk[cyc - 2] = rk_data;
        checkOutput($sformatf("rk_idx c%0d", cyc), 32'(rk_idx), 32'(cyc - 2));
        checkOutput($sformatf("rk_data r%0d", cyc - 2), rk_data, exp_rk[cyc - 2]);
      end
      if (cyc < 33) step();
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_in    = '0;
    rd_idx    = 5'd0;
    rd_dec    = 1'b0;

    // Reset state.
    repeat (3) step();
    checkOutput("rst key_ready", 32'(key_ready), 32'd1);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst keys_ok", 32'(keys_ok), 32'd0);
    checkOutput("rst rk_valid", 32'(rk_valid), 32'd0);
    checkOutput("rst done", 32'(done), 32'd0);
    checkOutput("rst rk_idx", 32'(rk_idx), 32'd0);
    checkOutput("rst rk_data", rk_data, 32'd0);
    checkOutput("rst rd_data", rd_data, 32'd0);
    checkOutput("rst ck_idx", 32'(ck_idx), 32'd0);
    rst_n = 1'b1;
    repeat (2) step();

    // Standard known-answer key.
    applyStimulus(KEY_A, 1'b0, '0);
    checkOutput("kat rk0", got_rk[0], 32'hF12186F9);
    checkOutput("kat rk1", got_rk[1], 32'h41662B61);
    checkOutput("kat rk31", got_rk[31], 32'h9124A012);
    step();
    checkOutput("post done", 32'(done), 32'd0);
    checkOutput("post rk_valid", 32'(rk_valid), 32'd0);
    checkOutput("post keys_ok", 32'(keys_ok), 32'd1);
    checkOutput("post key_ready", 32'(key_ready), 32'd1);

    // Read port, reverse and forward order.
    rd_idx = 5'd0;
    rd_dec = 1'b1;
    step();
    checkOutput("rd dec idx0", rd_data, 32'h9124A012);
    rd_dec = 1'b0;
    step();
    checkOutput("rd enc idx0", rd_data, 32'hF12186F9);
    rd_idx = 5'd5;
    rd_dec = 1'b1;
    step();
    checkOutput("rd dec idx5", rd_data, exp_rk[26]);
    rd_idx = 5'd31;
    rd_dec = 1'b0;
    step();
    checkOutput("rd enc idx31", rd_data, exp_rk[31]);

    // Key B held during A's run, then accepted back to back on the first idle cycle.
    applyStimulus(KEY_A, 1'b1, KEY_B);
    applyStimulus(KEY_B, 1'b0, '0);
    step();
    checkOutput("b post done", 32'(done), 32'd0);
    checkOutput("b post keys_ok", 32'(keys_ok), 32'd1);
    rd_idx = 5'd3;
    rd_dec = 1'b0;
    step();
    checkOutput("b rd enc idx3", rd_data, exp_rk[3]);

    // Reset in round 10, then reload the same key.
    key_valid = 1'b1;
    key_in    = KEY_A;
    step();
    key_valid = 1'b0;
    repeat (10) step();
    checkOutput("mid busy before", 32'(busy), 32'd1);
    checkOutput("mid ck_idx before", 32'(ck_idx), 32'd11);
    rst_n = 1'b0;
    #1;
    checkOutput("mid busy", 32'(busy), 32'd0);
    checkOutput("mid keys_ok", 32'(keys_ok), 32'd0);
    checkOutput("mid key_ready", 32'(key_ready), 32'd1);
    checkOutput("mid rk_valid", 32'(rk_valid), 32'd0);
    checkOutput("mid done", 32'(done), 32'd0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checkOutput($sformatf("mid after done c%0d", c), 32'(done), 32'd0);
      checkOutput($sformatf("mid after keys_ok c%0d", c), 32'(keys_ok), 32'd0);
      checkOutput($sformatf("mid after busy c%0d", c), 32'(busy), 32'd0);
    end
    applyStimulus(KEY_A, 1'b0, '0);
    checkOutput("reload rk0", got_rk[0], 32'hF12186F9);
    checkOutput("reload rk31", got_rk[31], 32'h9124A012);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
